// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with a double-buffered
// glyph frame, per-digit decimal point, blink and leading-zero blanking.
module seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 200,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [5*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      lz_en,
  input  logic                      load,
  output logic [7:0]                seg,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [SW-1:0]           slot_cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_ph;

  logic [5*NUM_DIGITS-1:0] act_digits, pend_digits;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
  logic [NUM_DIGITS-1:0]   act_blink, pend_blink;
  logic                    act_lz, pend_lz;
  logic                    pend_flag;

  logic                    slot_wrap;
  logic                    frame_wrap;

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_wrap && (idx == IDX_LAST);

  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'd0:    glyph = 7'b1000000;
      5'd1:    glyph = 7'b1111001;
      5'd2:    glyph = 7'b0100100;
      5'd3:    glyph = 7'b0110000;
      5'd4:    glyph = 7'b0011001;
      5'd5:    glyph = 7'b0010010;
      5'd6:    glyph = 7'b0000010;
      5'd7:    glyph = 7'b1111000;
      5'd8:    glyph = 7'b0000000;
      5'd9:    glyph = 7'b0010000;
      5'd10:   glyph = 7'b1000111;
      5'd11:   glyph = 7'b0101111;
      5'd12:   glyph = 7'b1001111;
      5'd13:   glyph = 7'b0101011;
      5'd14:   glyph = 7'b0000111;
      5'd15:   glyph = 7'b0001000;
      5'd16:   glyph = 7'b0000011;
      5'd17:   glyph = 7'b1000110;
      5'd18:   glyph = 7'b0100001;
      5'd19:   glyph = 7'b0000110;
      5'd20:   glyph = 7'b0001110;
      5'd21:   glyph = 7'b0001001;
      5'd22:   glyph = 7'b0001100;
      5'd23:   glyph = 7'b1000001;
      5'd24:   glyph = 7'b0111111;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // Slot, digit index and blink counters; all wrap explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      idx        <= '0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_wrap;
      if (slot_wrap) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // load is a single-cycle strobe with no back-pressure: it always succeeds.
  // Outside a frame boundary it fills the pending buffer (last load wins);
  // on the boundary cycle it writes the active buffer directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_digits  <= '1;
      pend_digits <= '1;
      act_dp      <= '0;
      pend_dp     <= '0;
      act_blink   <= '0;
      pend_blink  <= '0;
      act_lz      <= 1'b0;
      pend_lz     <= 1'b0;
      pend_flag   <= 1'b0;
    end else if (load && frame_wrap) begin
      act_digits <= digits;
      act_dp     <= dp_mask;
      act_blink  <= blink_mask;
      act_lz     <= lz_en;
      pend_flag  <= 1'b0;
    end else begin
      if (frame_wrap && pend_flag) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
        act_blink  <= pend_blink;
        act_lz     <= pend_lz;
        pend_flag  <= 1'b0;
      end
      if (load) begin
        pend_digits <= digits;
        pend_dp     <= dp_mask;
        pend_blink  <= blink_mask;
        pend_lz     <= lz_en;
        pend_flag   <= 1'b1;
      end
    end
  end

  logic [4:0]            cur_code;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  cur_lead;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] an_sel;
  logic                  suppress;

  // zero_run tracks "all digits from the top down to i are zero".
  always_comb begin
    cur_code  = 5'd31;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lead  = 1'b0;
    zero_run  = 1'b1;
    an_sel    = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_digits[5*i +: 5] == 5'd0);
      if (idx == IW'(i)) begin
        cur_code  = act_digits[5*i +: 5];
        cur_dp    = act_dp[i];
        cur_blink = act_blink[i];
        cur_lead  = zero_run;
        an_sel[i] = 1'b0;
      end
    end
  end

  assign suppress = (cur_blink && blink_ph) ||
                    (act_lz && (idx != '0) && cur_lead);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 8'hFF;
      an  <= '1;
    end else if ((slot_cnt < BLANK_END) || suppress) begin
      seg <= 8'hFF;
      an  <= '1;
    end else begin
      seg <= {~cur_dp, glyph(cur_code)};
      an  <= an_sel;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: table of frames with hand-computed
// segment/anode patterns plus double-buffer, reset and blink sequences.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] digits;
  logic [3:0]  dp_mask;
  logic [3:0]  blink_mask;
  logic        lz_en;
  logic        load;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  logic [3:0] s_an [32];
  logic [7:0] s_seg [32];

  seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(1), .BLINK_DIV(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .lz_en(lz_en), .load(load),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [19:0] dg;
    logic [3:0]  dp;
    logic        lz;
    logic [15:0] ea;
    logic [31:0] es;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [19:0] dg, input logic [3:0] dp,
                         input logic [3:0] bm, input logic lz);
    digits = dg; dp_mask = dp; blink_mask = bm; lz_en = lz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("frame_wait", {31'd0, frame_done}, 32'd1);
  endtask

  // Samples the 32 cycles of one frame; optionally strobes load at cycle load_at.
  task automatic capture_frame(input int load_at, input logic [19:0] dg,
                               input logic [3:0] dp, input logic [3:0] bm, input logic lz);
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      s_an[j-1] = an;
      s_seg[j-1] = seg;
      chk($sformatf("frame_done j=%0d", j), {31'd0, frame_done}, (j == 32) ? 32'd1 : 32'd0);
      if (j == load_at) begin
        digits = dg; dp_mask = dp; blink_mask = bm; lz_en = lz; load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [15:0] ea, input logic [31:0] es);
    logic [11:0] exp;
    for (int d = 0; d < 4; d++) begin
      for (int s = 0; s < 8; s++) begin
        exp = (s == 0) ? 12'hFFF : {ea[4*d +: 4], es[8*d +: 8]};
        chk($sformatf("%s d%0d s%0d an_seg", name, d, s),
            {20'd0, s_an[8*d+s], s_seg[8*d+s]}, {20'd0, exp});
      end
    end
  endtask

  initial begin
    int st[8];
    int nl, nb;

    vecs[0]  = '{{5'd3, 5'd2, 5'd1, 5'd0},     4'b0010, 1'b0, 16'h7BDE, 32'hB0A479C0};
    vecs[1]  = '{{5'd0, 5'd0, 5'd4, 5'd0},     4'b0000, 1'b1, 16'hFFDE, 32'hFFFF99C0};
    vecs[2]  = '{{5'd0, 5'd0, 5'd0, 5'd0},     4'b0000, 1'b1, 16'hFFFE, 32'hFFFFFFC0};
    vecs[3]  = '{{5'd0, 5'd0, 5'd0, 5'd0},     4'b0000, 1'b0, 16'h7BDE, 32'hC0C0C0C0};
    vecs[4]  = '{{5'd0, 5'd5, 5'd0, 5'd0},     4'b0000, 1'b1, 16'hFBDE, 32'hFF92C0C0};
    vecs[5]  = '{{5'd15, 5'd24, 5'd31, 5'd10}, 4'b0010, 1'b0, 16'h7BDE, 32'h88BF7FC7};
    vecs[6]  = '{{5'd11, 5'd12, 5'd13, 5'd14}, 4'b0000, 1'b0, 16'h7BDE, 32'hAFCFAB87};
    vecs[7]  = '{{5'd16, 5'd17, 5'd18, 5'd19}, 4'b0000, 1'b0, 16'h7BDE, 32'h83C6A186};
    vecs[8]  = '{{5'd20, 5'd21, 5'd22, 5'd23}, 4'b0000, 1'b0, 16'h7BDE, 32'h8E898CC1};
    vecs[9]  = '{{5'd25, 5'd26, 5'd27, 5'd28}, 4'b0000, 1'b0, 16'h7BDE, 32'hFFFFFFFF};
    vecs[10] = '{{5'd29, 5'd30, 5'd31, 5'd9},  4'b0000, 1'b0, 16'h7BDE, 32'hFFFFFF90};
    vecs[11] = '{{5'd0, 5'd0, 5'd0, 5'd0},     4'b1111, 1'b1, 16'hFFFE, 32'hFFFFFF40};
    vecs[12] = '{{5'd31, 5'd0, 5'd0, 5'd7},    4'b0000, 1'b1, 16'h7BDE, 32'hFFC0C0F8};
    vecs[13] = '{{5'd8, 5'd7, 5'd6, 5'd5},     4'b1000, 1'b0, 16'h7BDE, 32'h00F88292};

    // Clock/reset
    rst_n = 1'b0; digits = '0; dp_mask = '0; blink_mask = '0; lz_en = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset seg", {24'd0, seg}, 32'hFF);
    chk("reset an", {28'd0, an}, 32'hF);
    chk("reset frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    wait_frame();
    capture_frame(-1, '0, '0, '0, 1'b0);
    check_frame("post_reset_blank", 16'h7BDE, 32'hFFFFFFFF);

    // Table of frames
    for (int i = 0; i < 14; i++) begin
      do_load(vecs[i].dg, vecs[i].dp, 4'b0000, vecs[i].lz);
      wait_frame();
      capture_frame(-1, '0, '0, '0, 1'b0);
      check_frame($sformatf("vec%0d", i), vecs[i].ea, vecs[i].es);
    end

    // Double buffer: load mid-frame does not disturb the current frame
    do_load(vecs[0].dg, vecs[0].dp, 4'b0000, 1'b0);
    wait_frame();
    capture_frame(12, {5'd8, 5'd8, 5'd8, 5'd8}, 4'b0000, 4'b0000, 1'b0);
    check_frame("dbuf_old_frame", vecs[0].ea, vecs[0].es);
    // Load on the exact boundary cycle shows up in the frame that follows it
    capture_frame(31, vecs[13].dg, vecs[13].dp, 4'b0000, 1'b0);
    check_frame("dbuf_new_frame", 16'h7BDE, 32'h80808080);
    capture_frame(-1, '0, '0, '0, 1'b0);
    check_frame("boundary_load", vecs[13].ea, vecs[13].es);

    // Asynchronous reset in the middle of a lit slot, with a load pending
    repeat (4) @(negedge clk);
    do_load({5'd8, 5'd8, 5'd8, 5'd8}, 4'b1111, 4'b0000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset seg", {24'd0, seg}, 32'hFF);
    chk("async_reset an", {28'd0, an}, 32'hF);
    chk("async_reset frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    chk("held_reset seg", {24'd0, seg}, 32'hFF);
    rst_n = 1'b1;
    wait_frame();
    capture_frame(-1, '0, '0, '0, 1'b0);
    check_frame("after_async_reset", 16'h7BDE, 32'hFFFFFFFF);

    // Blink on digit 0 only: 64 cycles lit, 64 blanked
    do_load({5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, 4'b0001, 1'b0);
    wait_frame();
    for (int f = 0; f < 8; f++) begin
      capture_frame(-1, '0, '0, '0, 1'b0);
      nl = 0; nb = 0;
      for (int s = 1; s < 8; s++) begin
        if ({s_an[s], s_seg[s]} == 12'hEF9) nl++;
        else if ({s_an[s], s_seg[s]} == 12'hFFF) nb++;
      end
      chk($sformatf("blink d0 frame%0d whole", f), 32'((nl == 7) || (nb == 7)), 32'd1);
      st[f] = (nl == 7) ? 1 : 0;
      for (int d = 1; d < 4; d++) begin
        for (int s = 1; s < 8; s++) begin
          chk($sformatf("blink other d%0d f%0d", d, f), {20'd0, s_an[8*d+s], s_seg[8*d+s]},
              {20'd0, (d == 1) ? 4'hD : (d == 2) ? 4'hB : 4'h7, 8'hF9});
        end
      end
    end
    for (int f = 0; f < 6; f++) begin
      chk($sformatf("blink toggle f%0d", f), 32'(st[f] != st[f+2]), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
